// File: rtl/hsv_core_ctrlstatus_regs_arbiter.sv
// rtl/hsv_core_ctrlstatus_regs_arbiter.sv - two-port arbiter for the CSR register-file bus
// Optional round-robin arbitration: define HSV_CSR_ARB_ROUND_ROBIN_EN (default: fixed priority by B_PRIORITY).
// Request bundle {req, is_wr, addr[15:0], wr_data[31:0], wr_biten[31:0]};
// response bundle {stall_wr, stall_rd, rd_ack, rd_err, rd_data[31:0], wr_ack, wr_err}.
module hsv_core_ctrlstatus_regs_arbiter #(
   parameter int unsigned TIMEOUT    = 64,
   parameter bit          B_PRIORITY = 1'b1
) (
   input  logic        clk_core,
   input  logic        rst_core_n,
   input  logic [81:0] a_req,
   output logic [37:0] a_rsp,
   input  logic [81:0] b_req,
   output logic [37:0] b_rsp,
   output logic        regs_req,
   output logic        regs_req_is_wr,
   output logic [15:0] regs_addr,
   output logic [31:0] regs_wr_data,
   output logic [31:0] regs_wr_biten,
   input  logic        regs_req_stall_wr,
   input  logic        regs_req_stall_rd,
   input  logic        regs_rd_ack,
   input  logic        regs_rd_err,
   input  logic [31:0] regs_rd_data,
   input  logic        regs_wr_ack,
   input  logic        regs_wr_err,
   output logic        arb_timeout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

   // Stalled, no acks, zero data: what every non-owner and every idle port sees.
   localparam logic [37:0] RSP_IDLE = {2'b11, 36'd0};
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;      // 0 = A, 1 = B
   logic [15:0] cnt_q, cnt_d;
   logic        lat_wr_q, lat_wr_d;
   logic        both_pick;

   logic [81:0] own_bundle;
   logic        own_req, own_is_wr, own_stall;
   logic [37:0] own_rsp;
   logic        ack_match, timed_out;

   assign own_bundle = owner_q ? b_req : a_req;
   assign own_req    = own_bundle[81];
   assign own_is_wr  = own_bundle[80];
   assign own_stall  = own_is_wr ? regs_req_stall_wr : regs_req_stall_rd;
   assign ack_match  = lat_wr_q ? regs_wr_ack : regs_rd_ack;
   assign timed_out  = (state_q == WAIT_ACK) && !ack_match && (cnt_q == CNT_LAST);

`ifdef HSV_CSR_ARB_ROUND_ROBIN_EN
   logic rr_q;  // last granted port

   // Remember the port granted on each ISSUE entry so ties alternate.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n)
         rr_q <= 1'b0;
      else if (state_q == IDLE && state_d == ISSUE)
         rr_q <= owner_d;
   end

   assign both_pick = ~rr_q;
`else
   assign both_pick = B_PRIORITY;
`endif

   // Arbiter state, owner, wait counter and latched transaction type.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         cnt_q    <= 16'd0;
         lat_wr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         lat_wr_q <= lat_wr_d;
      end
   end

   // Next-state, downstream mux and per-port response routing.
   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      cnt_d          = cnt_q;
      lat_wr_d       = lat_wr_q;
      regs_req       = 1'b0;
      regs_req_is_wr = own_is_wr;
      regs_addr      = own_bundle[79:64];
      regs_wr_data   = own_bundle[63:32];
      regs_wr_biten  = own_bundle[31:0];
      own_rsp        = RSP_IDLE;
      arb_timeout    = 1'b0;

      case (state_q)
         IDLE: begin
            if (a_req[81] && b_req[81]) begin
               owner_d = both_pick;
               state_d = ISSUE;
            end else if (a_req[81]) begin
               owner_d = 1'b0;
               state_d = ISSUE;
            end else if (b_req[81]) begin
               owner_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            regs_req        = own_req;
            own_rsp[37]     = regs_req_stall_wr;
            own_rsp[36]     = regs_req_stall_rd;
            if (!own_req) begin
               state_d = IDLE;
            end else if (!own_stall) begin
               lat_wr_d = own_is_wr;
               cnt_d    = 16'd0;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            cnt_d = cnt_q + 16'd1;
            if (ack_match) begin
               if (lat_wr_q) begin
                  own_rsp[1] = 1'b1;
                  own_rsp[0] = regs_wr_err;
               end else begin
                  own_rsp[35]   = 1'b1;
                  own_rsp[34]   = regs_rd_err;
                  own_rsp[33:2] = regs_rd_data;
               end
               state_d = IDLE;
            end else if (timed_out) begin
               if (lat_wr_q) begin
                  own_rsp[1] = 1'b1;
                  own_rsp[0] = 1'b1;
               end else begin
                  own_rsp[35] = 1'b1;
                  own_rsp[34] = 1'b1;
               end
               arb_timeout = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      a_rsp = owner_q ? RSP_IDLE : own_rsp;
      b_rsp = owner_q ? own_rsp : RSP_IDLE;
   end

endmodule

// File: tb/tb_hsv_core_ctrlstatus_regs_arbiter.sv
// tb/tb_hsv_core_ctrlstatus_regs_arbiter.sv - directed self-checking bench for the CSR bus arbiter
`timescale 1ns/1ps
module tb_hsv_core_ctrlstatus_regs_arbiter;

   localparam logic [37:0] RSP_IDLE = {2'b11, 36'd0};

   logic        clk_core = 1'b0;
   logic        rst_core_n = 1'b0;
   logic [81:0] a_req = '0;
   logic [81:0] b_req = '0;
   logic [37:0] a_rsp, b_rsp;
   logic        regs_req, regs_req_is_wr;
   logic [15:0] regs_addr;
   logic [31:0] regs_wr_data, regs_wr_biten;
   logic        regs_req_stall_wr = 1'b0;
   logic        regs_req_stall_rd = 1'b0;
   logic        regs_rd_ack = 1'b0;
   logic        regs_rd_err = 1'b0;
   logic [31:0] regs_rd_data = '0;
   logic        regs_wr_ack = 1'b0;
   logic        regs_wr_err = 1'b0;
   logic        arb_timeout;

   int passed = 0;
   int total  = 0;

   hsv_core_ctrlstatus_regs_arbiter #(.TIMEOUT(8), .B_PRIORITY(1'b1)) dut (
      .clk_core(clk_core), .rst_core_n(rst_core_n),
      .a_req(a_req), .a_rsp(a_rsp), .b_req(b_req), .b_rsp(b_rsp),
      .regs_req(regs_req), .regs_req_is_wr(regs_req_is_wr), .regs_addr(regs_addr),
      .regs_wr_data(regs_wr_data), .regs_wr_biten(regs_wr_biten),
      .regs_req_stall_wr(regs_req_stall_wr), .regs_req_stall_rd(regs_req_stall_rd),
      .regs_rd_ack(regs_rd_ack), .regs_rd_err(regs_rd_err), .regs_rd_data(regs_rd_data),
      .regs_wr_ack(regs_wr_ack), .regs_wr_err(regs_wr_err), .arb_timeout(arb_timeout)
   );

   always #5 clk_core = ~clk_core;

   function automatic logic [81:0] mk_req(input logic wr, input logic [15:0] addr,
                                          input logic [31:0] d, input logic [31:0] be);
      return {1'b1, wr, addr, d, be};
   endfunction

   task automatic cyc();
      @(posedge clk_core);
      #2;
   endtask

   task automatic test_reset();
      #1;
      total++; if (a_rsp !== RSP_IDLE) $display("FAIL reset_a_rsp: got %h want %h", a_rsp, RSP_IDLE); else passed++;
      total++; if (b_rsp !== RSP_IDLE) $display("FAIL reset_b_rsp: got %h want %h", b_rsp, RSP_IDLE); else passed++;
      total++; if (regs_req !== 1'b0) $display("FAIL reset_regs_req: got %b want 0", regs_req); else passed++;
      total++; if (arb_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", arb_timeout); else passed++;
      cyc();
      rst_core_n = 1'b1;
      cyc();
   endtask

   task automatic test_a_read();
      a_req = mk_req(1'b0, 16'h3000, 32'h0, 32'h0);
      #1;
      total++; if (a_rsp[37:36] !== 2'b11) $display("FAIL aread_idle_stall: got %b want 11", a_rsp[37:36]); else passed++;
      cyc();
      #1;
      total++; if ({regs_req, regs_req_is_wr, regs_addr} !== {1'b1, 1'b0, 16'h3000}) $display("FAIL aread_issue: got %b %b %h want 1 0 3000", regs_req, regs_req_is_wr, regs_addr); else passed++;
      total++; if (a_rsp[36] !== 1'b0) $display("FAIL aread_stall_rd: got %b want 0", a_rsp[36]); else passed++;
      cyc();
      a_req = '0;
      #1;
      total++; if (regs_req !== 1'b0 || a_rsp[35] !== 1'b0) $display("FAIL aread_wait: got req=%b ack=%b want 0 0", regs_req, a_rsp[35]); else passed++;
      cyc();
      regs_rd_ack = 1'b1; regs_rd_data = 32'hDEADBEEF;
      #1;
      total++; if (a_rsp[35:2] !== {1'b1, 1'b0, 32'hDEADBEEF}) $display("FAIL aread_ack: got %h want %h", a_rsp[35:2], {2'b10, 32'hDEADBEEF}); else passed++;
      total++; if (b_rsp !== RSP_IDLE) $display("FAIL aread_b_quiet: got %h want %h", b_rsp, RSP_IDLE); else passed++;
      cyc();
      regs_rd_ack = 1'b0; regs_rd_data = '0;
      #1;
      total++; if (a_rsp !== RSP_IDLE) $display("FAIL aread_after: got %h want %h", a_rsp, RSP_IDLE); else passed++;
   endtask

   task automatic test_simultaneous();
      a_req = mk_req(1'b0, 16'h0300, 32'h0, 32'h0);
      b_req = mk_req(1'b1, 16'h0341, 32'h12345678, 32'hFFFFFFFF);
      cyc();
      #1;
      total++; if ({regs_req, regs_req_is_wr, regs_addr} !== {1'b1, 1'b1, 16'h0341}) $display("FAIL sim_b_first: got %b %b %h want 1 1 0341", regs_req, regs_req_is_wr, regs_addr); else passed++;
      total++; if (b_rsp[37] !== 1'b0 || a_rsp[37:36] !== 2'b11) $display("FAIL sim_stalls: got b=%b a=%b want 0 11", b_rsp[37], a_rsp[37:36]); else passed++;
      cyc();
      b_req = '0;
      #1;
      total++; if (a_rsp[37:36] !== 2'b11) $display("FAIL sim_a_wait_stall: got %b want 11", a_rsp[37:36]); else passed++;
      cyc();
      regs_wr_ack = 1'b1;
      #1;
      total++; if (b_rsp[1:0] !== 2'b10 || a_rsp[35] !== 1'b0 || a_rsp[1] !== 1'b0) $display("FAIL sim_b_wr_ack: got b=%b a_rd=%b a_wr=%b want 10 0 0", b_rsp[1:0], a_rsp[35], a_rsp[1]); else passed++;
      cyc();
      regs_wr_ack = 1'b0;
      #1;
      total++; if (a_rsp[37:36] !== 2'b11) $display("FAIL sim_a_idle_stall: got %b want 11", a_rsp[37:36]); else passed++;
      cyc();
      #1;
      total++; if ({regs_req, regs_addr, a_rsp[36]} !== {1'b1, 16'h0300, 1'b0}) $display("FAIL sim_a_granted: got %b %h %b want 1 0300 0", regs_req, regs_addr, a_rsp[36]); else passed++;
      cyc();
      a_req = '0;
      regs_rd_ack = 1'b1; regs_rd_data = 32'h00000055;
      #1;
      total++; if (a_rsp[35:2] !== {2'b10, 32'h00000055}) $display("FAIL sim_a_ack: got %h want %h", a_rsp[35:2], {2'b10, 32'h55}); else passed++;
      cyc();
      #1;
      total++; if (a_rsp !== RSP_IDLE || b_rsp !== RSP_IDLE) $display("FAIL stray_ack_idle: got a=%h b=%h want %h", a_rsp, b_rsp, RSP_IDLE); else passed++;
      regs_rd_ack = 1'b0; regs_rd_data = '0;
   endtask

   task automatic test_b_stall();
      int req_cycles;
      req_cycles = 0;
      regs_req_stall_wr = 1'b1;
      b_req = mk_req(1'b1, 16'h0342, 32'hA5A50F0F, 32'h0000FFFF);
      cyc();
      for (int i = 0; i < 3; i++) begin
         #1;
         if (regs_req === 1'b1 && b_rsp[37] === 1'b1) req_cycles++;
         cyc();
      end
      total++; if (req_cycles !== 3) $display("FAIL bstall_req_cycles: got %0d want 3", req_cycles); else passed++;
      regs_req_stall_wr = 1'b0;
      #1;
      total++; if ({regs_req, b_rsp[37]} !== 2'b10) $display("FAIL bstall_accept: got %b want 10", {regs_req, b_rsp[37]}); else passed++;
      total++; if ({regs_wr_data, regs_wr_biten} !== {32'hA5A50F0F, 32'h0000FFFF}) $display("FAIL bstall_data: got %h %h want a5a50f0f 0000ffff", regs_wr_data, regs_wr_biten); else passed++;
      cyc();
      b_req = '0;
      regs_wr_ack = 1'b1; regs_wr_err = 1'b1;
      #1;
      total++; if (b_rsp[1:0] !== 2'b11) $display("FAIL bstall_wr_err: got %b want 11", b_rsp[1:0]); else passed++;
      cyc();
      regs_wr_ack = 1'b0; regs_wr_err = 1'b0;
   endtask

   task automatic test_timeout();
      int pulses;
      int early_acks;
      pulses = 0; early_acks = 0;
      a_req = mk_req(1'b0, 16'h0305, 32'h0, 32'h0);
      cyc();
      cyc();
      a_req = '0;
      for (int i = 0; i < 7; i++) begin
         regs_wr_ack = (i == 2);
         #1;
         if (a_rsp[35] !== 1'b0 || a_rsp[1] !== 1'b0) early_acks++;
         if (arb_timeout === 1'b1) pulses++;
         cyc();
      end
      regs_wr_ack = 1'b0;
      total++; if (early_acks !== 0) $display("FAIL to_early_ack: got %0d want 0", early_acks); else passed++;
      #1;
      total++; if (a_rsp[35:2] !== {2'b11, 32'h0}) $display("FAIL to_err_ack: got %h want %h", a_rsp[35:2], {2'b11, 32'h0}); else passed++;
      if (arb_timeout === 1'b1) pulses++;
      cyc();
      regs_rd_ack = 1'b1; regs_rd_data = 32'h11111111;
      #1;
      if (arb_timeout === 1'b1) pulses++;
      total++; if (pulses !== 1) $display("FAIL to_pulse_count: got %0d want 1", pulses); else passed++;
      total++; if (a_rsp !== RSP_IDLE) $display("FAIL to_late_ack: got %h want %h", a_rsp, RSP_IDLE); else passed++;
      cyc();
      regs_rd_ack = 1'b0; regs_rd_data = '0;
      // Real ack on the timeout cycle must win over the synthesized error.
      a_req = mk_req(1'b0, 16'h0306, 32'h0, 32'h0);
      cyc();
      cyc();
      a_req = '0;
      for (int i = 0; i < 7; i++) cyc();
      regs_rd_ack = 1'b1; regs_rd_data = 32'hCAFE0001;
      #1;
      total++; if ({a_rsp[35:2], arb_timeout} !== {2'b10, 32'hCAFE0001, 1'b0}) $display("FAIL to_ack_wins: got %h %b want %h 0", a_rsp[35:2], arb_timeout, {2'b10, 32'hCAFE0001}); else passed++;
      cyc();
      regs_rd_ack = 1'b0; regs_rd_data = '0;
   endtask

   task automatic test_reset_mid();
      a_req = mk_req(1'b0, 16'h0307, 32'h0, 32'h0);
      cyc();
      cyc();
      a_req = '0;
      rst_core_n = 1'b0;
      #1;
      total++; if ({a_rsp, b_rsp, regs_req, arb_timeout} !== {RSP_IDLE, RSP_IDLE, 2'b00}) $display("FAIL rstmid_outputs: got %h %h %b %b", a_rsp, b_rsp, regs_req, arb_timeout); else passed++;
      cyc();
      rst_core_n = 1'b1;
      cyc();
      regs_rd_ack = 1'b1; regs_rd_data = 32'h77777777;
      #1;
      total++; if (a_rsp !== RSP_IDLE || b_rsp !== RSP_IDLE) $display("FAIL rstmid_no_ack: got a=%h b=%h want %h", a_rsp, b_rsp, RSP_IDLE); else passed++;
      cyc();
      regs_rd_ack = 1'b0; regs_rd_data = '0;
   endtask

   initial begin
      test_reset();
      test_a_read();
      test_simultaneous();
      test_b_stall();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
